// File: rtl/ex_wb_pipe_regs_if.sv
// Bundle of control, data and observation signals between the EX stage,
// the EX/MEM + MEM/WB pipeline registers and their consumers (forwarding
// unit, ALU operand muxes, data memory and register-file write port).
// The master side drives the EX-stage fields and hazard controls; the
// slave side is the pipeline-register block itself.
interface ex_wb_pipe_regs_if #(
   parameter int DATA_W     = 32,
   parameter int REG_ADDR_W = 5
);

   // Hazard-unit controls
   logic                  stall_i;
   logic                  flush_i;

   // EX-stage instruction presented for capture
   logic                  ex_valid_i;
   logic                  ex_RegWrite_i;
   logic                  ex_MemtoReg_i;
   logic                  ex_MemRead_i;
   logic                  ex_MemWrite_i;
   logic [REG_ADDR_W-1:0] ex_RegisterRd_i;
   logic [DATA_W-1:0]     ex_ALUResult_i;
   logic [DATA_W-1:0]     ex_WriteData_i;

   // Data-memory read data, addressed by EX_MEM_ALUResult_o
   logic [DATA_W-1:0]     mem_ReadData_i;

   // EX/MEM register view
   logic                  EX_MEM_RegWrite_o;
   logic [REG_ADDR_W-1:0] EX_MEM_RegisterRd_o;
   logic [DATA_W-1:0]     EX_MEM_ALUResult_o;
   logic                  EX_MEM_MemRead_o;
   logic                  EX_MEM_MemWrite_o;
   logic [DATA_W-1:0]     EX_MEM_WriteData_o;

   // MEM/WB register view
   logic                  MEM_WB_RegWrite_o;
   logic [REG_ADDR_W-1:0] MEM_WB_RegisterRd_o;
   logic [DATA_W-1:0]     MEM_WB_WriteData_o;

   // Retirement statistics
   logic [31:0]           retired_cnt_o;

   // Upstream pipeline / hazard unit / memory model side
   modport master (
      output stall_i, flush_i,
      output ex_valid_i, ex_RegWrite_i, ex_MemtoReg_i, ex_MemRead_i, ex_MemWrite_i,
      output ex_RegisterRd_i, ex_ALUResult_i, ex_WriteData_i,
      output mem_ReadData_i,
      input  EX_MEM_RegWrite_o, EX_MEM_RegisterRd_o, EX_MEM_ALUResult_o,
      input  EX_MEM_MemRead_o, EX_MEM_MemWrite_o, EX_MEM_WriteData_o,
      input  MEM_WB_RegWrite_o, MEM_WB_RegisterRd_o, MEM_WB_WriteData_o,
      input  retired_cnt_o
   );

   // Pipeline-register block side
   modport slave (
      input  stall_i, flush_i,
      input  ex_valid_i, ex_RegWrite_i, ex_MemtoReg_i, ex_MemRead_i, ex_MemWrite_i,
      input  ex_RegisterRd_i, ex_ALUResult_i, ex_WriteData_i,
      input  mem_ReadData_i,
      output EX_MEM_RegWrite_o, EX_MEM_RegisterRd_o, EX_MEM_ALUResult_o,
      output EX_MEM_MemRead_o, EX_MEM_MemWrite_o, EX_MEM_WriteData_o,
      output MEM_WB_RegWrite_o, MEM_WB_RegisterRd_o, MEM_WB_WriteData_o,
      output retired_cnt_o
   );

endinterface

// File: rtl/ex_wb_pipe_regs.sv
// EX/MEM and MEM/WB pipeline registers of the 5-stage MIPS pipeline.
// Every output is either a register or a register ANDed with its stored
// valid bit, so there is no combinational path from any input to any
// output. Stall freezes both stages, flush turns the EX/MEM capture into a
// bubble (and wins over stall for EX/MEM only), and a 32-bit counter
// tallies instructions leaving the WB stage.
module ex_wb_pipe_regs #(
   parameter int DATA_W     = 32,
   parameter int REG_ADDR_W = 5
) (
   input logic             clk_i,
   input logic             rst_i,
   ex_wb_pipe_regs_if.slave bus
);

   // Contents of the EX/MEM register
   typedef struct packed {
      logic                  valid;
      logic                  regWrite;
      logic                  memtoReg;
      logic                  memRead;
      logic                  memWrite;
      logic [REG_ADDR_W-1:0] rd;
      logic [DATA_W-1:0]     aluResult;
      logic [DATA_W-1:0]     writeData;
   } memStageT;

   // Contents of the MEM/WB register
   typedef struct packed {
      logic                  valid;
      logic                  regWrite;
      logic [REG_ADDR_W-1:0] rd;
      logic [DATA_W-1:0]     data;
   } wbStageT;

   // A bubble is the all-zero encoding of each stage
   localparam memStageT MEM_BUBBLE = '0;
   localparam wbStageT  WB_BUBBLE  = '0;

   memStageT    memStage;
   memStageT    memNext;
   wbStageT     wbStage;
   wbStageT     wbNext;
   logic [DATA_W-1:0] wbCaptureData;
   logic        retireNow;
   logic [31:0] retiredCnt;
   logic [31:0] retiredCntNext;

   // Writeback data is chosen when MEM/WB captures, so the memory read data
   // only has to be valid in the cycle the load sits in EX/MEM
   assign wbCaptureData = memStage.memtoReg ? bus.mem_ReadData_i : memStage.aluResult;

   // An instruction leaves WB whenever the pipe advances with a real one there,
   // regardless of whether it writes the register file
   assign retireNow      = ~bus.stall_i & wbStage.valid;
   assign retiredCntNext = retiredCnt + {31'b0, retireNow};

   // Next EX/MEM contents: flush beats stall, stall holds, otherwise capture EX
   always_comb begin
      memNext = memStage;
      if (bus.flush_i) begin
         memNext = MEM_BUBBLE;
      end else if (!bus.stall_i) begin
         if (bus.ex_valid_i) begin
            memNext.valid     = 1'b1;
            memNext.regWrite  = bus.ex_RegWrite_i;
            memNext.memtoReg  = bus.ex_MemtoReg_i;
            memNext.memRead   = bus.ex_MemRead_i;
            memNext.memWrite  = bus.ex_MemWrite_i;
            memNext.rd        = bus.ex_RegisterRd_i;
            memNext.aluResult = bus.ex_ALUResult_i;
            memNext.writeData = bus.ex_WriteData_i;
         end else begin
            memNext = MEM_BUBBLE;
         end
      end
   end

   // Next MEM/WB contents: advance from EX/MEM unless stalled (flush does not touch WB)
   always_comb begin
      wbNext = wbStage;
      if (!bus.stall_i) begin
         wbNext.valid    = memStage.valid;
         wbNext.regWrite = memStage.regWrite;
         wbNext.rd       = memStage.rd;
         wbNext.data     = wbCaptureData;
      end
   end

   // State register for both stages and the retirement counter; reset wins over everything
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         memStage   <= MEM_BUBBLE;
         wbStage    <= WB_BUBBLE;
         retiredCnt <= '0;
      end else begin
         memStage   <= memNext;
         wbStage    <= wbNext;
         retiredCnt <= retiredCntNext;
      end
   end

   // Control outputs are gated by valid so a bubble can never write or access memory
   assign bus.EX_MEM_RegWrite_o   = memStage.regWrite & memStage.valid;
   assign bus.EX_MEM_MemRead_o    = memStage.memRead  & memStage.valid;
   assign bus.EX_MEM_MemWrite_o   = memStage.memWrite & memStage.valid;
   assign bus.EX_MEM_RegisterRd_o = memStage.rd;
   assign bus.EX_MEM_ALUResult_o  = memStage.aluResult;
   assign bus.EX_MEM_WriteData_o  = memStage.writeData;

   assign bus.MEM_WB_RegWrite_o   = wbStage.regWrite & wbStage.valid;
   assign bus.MEM_WB_RegisterRd_o = wbStage.rd;
   assign bus.MEM_WB_WriteData_o  = wbStage.data;

   assign bus.retired_cnt_o       = retiredCnt;

endmodule

// File: tb/tb_ex_wb_pipe_regs.sv
// Scoreboard bench for ex_wb_pipe_regs. A driver applies one stimulus per
// cycle at the falling edge and pushes the outputs the reference model
// predicts for after the next rising edge; a monitor pops and compares one
// entry per cycle shortly after each rising edge.
module tb_ex_wb_pipe_regs;

   typedef struct {
      bit        rst;
      bit        stall;
      bit        flush;
      bit        valid;
      bit        regWrite;
      bit        memToReg;
      bit        memRead;
      bit        memWrite;
      bit [4:0]  rd;
      bit [31:0] alu;
      bit [31:0] wdata;
      bit [31:0] readData;
   } stimT;

   typedef struct {
      bit        exMemRegWrite;
      bit [4:0]  exMemRd;
      bit [31:0] exMemAlu;
      bit        exMemRead;
      bit        exMemWrite;
      bit [31:0] exMemWdata;
      bit        wbRegWrite;
      bit [4:0]  wbRd;
      bit [31:0] wbData;
      bit [31:0] cnt;
   } expT;

   // Instruction record as seen by the reference model
   typedef struct {
      bit        valid;
      bit        regWrite;
      bit        memToReg;
      bit        memRead;
      bit        memWrite;
      bit [4:0]  rd;
      bit [31:0] alu;
      bit [31:0] wdata;
   } instrT;

   typedef struct {
      bit        valid;
      bit        regWrite;
      bit [4:0]  rd;
      bit [31:0] data;
   } retireT;

   logic clock = 1'b0;
   logic reset = 1'b1;

   ex_wb_pipe_regs_if #(.DATA_W(32), .REG_ADDR_W(5)) bus ();

   ex_wb_pipe_regs #(.DATA_W(32), .REG_ADDR_W(5)) dut (
      .clk_i (clock),
      .rst_i (reset),
      .bus   (bus.slave)
   );

   always #5 clock = ~clock;

   expT    expQ[$];
   int     vectorsApplied = 0;
   int     miscompares    = 0;
   instrT  inMem;
   retireT inWb;
   bit [31:0] modelCnt;
   bit     preloadPending = 0;
   bit     forceActive    = 0;

   function automatic stimT idleStim();
      stimT s;
      s = '{default: '0};
      s.readData = $urandom;
      return s;
   endfunction

   function automatic stimT randStim();
      stimT s;
      s.rst      = ($urandom_range(0, 49) == 0);
      s.stall    = ($urandom_range(0, 4) == 0);
      s.flush    = ($urandom_range(0, 6) == 0);
      s.valid    = ($urandom_range(0, 3) != 0);
      s.regWrite = $urandom_range(0, 1);
      s.memToReg = $urandom_range(0, 1);
      s.memRead  = $urandom_range(0, 1);
      s.memWrite = $urandom_range(0, 1);
      s.rd       = 5'($urandom_range(0, 31));
      s.alu      = $urandom;
      s.wdata    = $urandom;
      s.readData = $urandom;
      return s;
   endfunction

   // Drive one cycle of stimulus and predict the result of the following edge
   task automatic applyStimulus(input stimT s);
      instrT  nextMem;
      retireT nextWb;
      bit [31:0] nextCnt;
      expT    e;
      @(negedge clock);
      if (forceActive) begin
         release dut.retiredCntNext;
         forceActive = 0;
      end
      reset              = s.rst;
      bus.stall_i        = s.stall;
      bus.flush_i        = s.flush;
      bus.ex_valid_i     = s.valid;
      bus.ex_RegWrite_i  = s.regWrite;
      bus.ex_MemtoReg_i  = s.memToReg;
      bus.ex_MemRead_i   = s.memRead;
      bus.ex_MemWrite_i  = s.memWrite;
      bus.ex_RegisterRd_i = s.rd;
      bus.ex_ALUResult_i = s.alu;
      bus.ex_WriteData_i = s.wdata;
      bus.mem_ReadData_i = s.readData;

      if (s.rst) begin
         nextMem = '{default: '0};
         nextWb  = '{default: '0};
         nextCnt = 0;
      end else begin
         nextCnt = modelCnt + ((!s.stall && inWb.valid) ? 32'd1 : 32'd0);
         if (s.stall) nextWb = inWb;
         else begin
            nextWb.valid    = inMem.valid;
            nextWb.regWrite = inMem.regWrite;
            nextWb.rd       = inMem.rd;
            nextWb.data     = inMem.memToReg ? s.readData : inMem.alu;
         end
         if (s.flush)       nextMem = '{default: '0};
         else if (s.stall)  nextMem = inMem;
         else if (!s.valid) nextMem = '{default: '0};
         else nextMem = '{valid: 1'b1, regWrite: s.regWrite, memToReg: s.memToReg,
                          memRead: s.memRead, memWrite: s.memWrite, rd: s.rd,
                          alu: s.alu, wdata: s.wdata};
      end
      if (preloadPending) begin
         force dut.retiredCntNext = 32'hFFFF_FFFE;
         forceActive    = 1;
         preloadPending = 0;
         if (!s.rst) nextCnt = 32'hFFFF_FFFE;
      end
      inMem    = nextMem;
      inWb     = nextWb;
      modelCnt = nextCnt;

      e.exMemRegWrite = inMem.valid & inMem.regWrite;
      e.exMemRead     = inMem.valid & inMem.memRead;
      e.exMemWrite    = inMem.valid & inMem.memWrite;
      e.exMemRd       = inMem.rd;
      e.exMemAlu      = inMem.alu;
      e.exMemWdata    = inMem.wdata;
      e.wbRegWrite    = inWb.valid & inWb.regWrite;
      e.wbRd          = inWb.rd;
      e.wbData        = inWb.data;
      e.cnt           = modelCnt;
      expQ.push_back(e);
   endtask

   task automatic cmpField(input string name, input bit [31:0] act, input bit [31:0] exp,
                           inout bit bad);
      if (act !== exp) begin
         $display("[TB] FAIL %s vector %0d: got 0x%08h expected 0x%08h", name, vectorsApplied, act, exp);
         bad = 1;
      end
   endtask

   // Compare every visible output against one scoreboard entry
   task automatic checkOutput(input expT e);
      bit bad = 0;
      vectorsApplied++;
      cmpField("EX_MEM_RegWrite",   32'(bus.EX_MEM_RegWrite_o),   32'(e.exMemRegWrite), bad);
      cmpField("EX_MEM_RegisterRd", 32'(bus.EX_MEM_RegisterRd_o), 32'(e.exMemRd),       bad);
      cmpField("EX_MEM_ALUResult",  bus.EX_MEM_ALUResult_o,       e.exMemAlu,           bad);
      cmpField("EX_MEM_MemRead",    32'(bus.EX_MEM_MemRead_o),    32'(e.exMemRead),     bad);
      cmpField("EX_MEM_MemWrite",   32'(bus.EX_MEM_MemWrite_o),   32'(e.exMemWrite),    bad);
      cmpField("EX_MEM_WriteData",  bus.EX_MEM_WriteData_o,       e.exMemWdata,         bad);
      cmpField("MEM_WB_RegWrite",   32'(bus.MEM_WB_RegWrite_o),   32'(e.wbRegWrite),    bad);
      cmpField("MEM_WB_RegisterRd", 32'(bus.MEM_WB_RegisterRd_o), 32'(e.wbRd),          bad);
      cmpField("MEM_WB_WriteData",  bus.MEM_WB_WriteData_o,       e.wbData,             bad);
      cmpField("retired_cnt",       bus.retired_cnt_o,            e.cnt,                bad);
      if (bad) miscompares++;
   endtask

   // Monitor: one scoreboard entry is due after every rising edge once driving starts
   always @(posedge clock) begin
      expT e;
      #1;
      if (expQ.size() != 0) begin
         e = expQ.pop_front();
         checkOutput(e);
      end
   end

   initial begin
      stimT s;
      inMem    = '{default: '0};
      inWb     = '{default: '0};
      modelCnt = 0;
      bus.stall_i = 1'b0; bus.flush_i = 1'b0; bus.ex_valid_i = 1'b0;
      bus.ex_RegWrite_i = 1'b0; bus.ex_MemtoReg_i = 1'b0; bus.ex_MemRead_i = 1'b0;
      bus.ex_MemWrite_i = 1'b0; bus.ex_RegisterRd_i = '0; bus.ex_ALUResult_i = '0;
      bus.ex_WriteData_i = '0; bus.mem_ReadData_i = '0;

      $display("[TB] reset with stall and random inputs");
      for (int i = 0; i < 2; i++) begin
         s = randStim(); s.rst = 1; s.stall = 1;
         applyStimulus(s);
      end

      $display("[TB] load reaching writeback");
      s = idleStim(); s.valid = 1; s.regWrite = 1; s.memToReg = 1; s.memRead = 1;
      s.rd = 8; s.alu = 32'h100;
      applyStimulus(s);
      s = idleStim(); s.readData = 32'hDEADBEEF;
      applyStimulus(s);
      applyStimulus(idleStim());
      applyStimulus(idleStim());

      $display("[TB] back-to-back ALU ops");
      s = idleStim(); s.valid = 1; s.regWrite = 1; s.rd = 3; s.alu = 7;
      applyStimulus(s);
      s = idleStim(); s.valid = 1; s.regWrite = 1; s.rd = 4; s.alu = 2;
      applyStimulus(s);
      applyStimulus(idleStim());

      $display("[TB] store held by stall");
      s = idleStim(); s.valid = 1; s.memWrite = 1; s.alu = 32'h40; s.wdata = 32'h55;
      applyStimulus(s);
      for (int i = 0; i < 3; i++) begin
         s = randStim(); s.rst = 0; s.stall = 1; s.flush = 0;
         applyStimulus(s);
      end
      applyStimulus(idleStim());
      applyStimulus(idleStim());

      $display("[TB] flush alone, then flush with stall");
      s = idleStim(); s.valid = 1; s.regWrite = 1; s.rd = 9;  s.alu = 32'h11;
      applyStimulus(s);
      s = idleStim(); s.valid = 1; s.regWrite = 1; s.rd = 10; s.alu = 32'h22;
      applyStimulus(s);
      s = idleStim(); s.valid = 1; s.regWrite = 1; s.rd = 13; s.alu = 32'h33; s.flush = 1;
      applyStimulus(s);
      s = idleStim(); s.valid = 1; s.regWrite = 1; s.rd = 11; s.alu = 32'h44;
      applyStimulus(s);
      s = idleStim(); s.valid = 1; s.regWrite = 1; s.rd = 12; s.alu = 32'h55;
      applyStimulus(s);
      s = idleStim(); s.valid = 1; s.regWrite = 1; s.rd = 14; s.alu = 32'h66;
      s.flush = 1; s.stall = 1;
      applyStimulus(s);
      s = idleStim(); s.valid = 1; s.regWrite = 1; s.rd = 0; s.alu = 32'h77;
      applyStimulus(s);
      applyStimulus(idleStim());
      applyStimulus(idleStim());

      $display("[TB] retired counter wrap");
      for (int i = 0; i < 8; i++) begin
         s = idleStim(); s.valid = 1; s.regWrite = 1;
         s.rd = 5'(i + 1); s.alu = 32'(i * 3);
         if (i == 4) preloadPending = 1;
         applyStimulus(s);
      end
      applyStimulus(idleStim());

      $display("[TB] randomized traffic");
      for (int i = 0; i < 400; i++) applyStimulus(randStim());
      applyStimulus(idleStim());

      for (int i = 0; i < 5 && expQ.size() != 0; i++) @(posedge clock);
      #3;
      if (expQ.size() != 0) begin
         $display("[TB] FAIL scoreboard_drain: %0d entries left, expected 0", expQ.size());
         miscompares++;
      end
      $display("== %0d vectors applied, %0d miscompares ==", vectorsApplied, miscompares);
      $finish;
   end

endmodule
